// File: rtl/code_mem_flash_writer_if.sv
// Bus bundle between the flash writer and its three slaves: the code RAM
// read port, the onchip_flash data slave and the onchip_flash CSR slave.
// master = flash writer side, slave = memory / flash side.
interface code_mem_flash_writer_if #(
    parameter int AW               = 13,
    parameter int FLASH_ADDR_WIDTH = 13
);
    // code RAM read port
    logic                        pram_re;
    logic [AW-1:0]               pram_addr;
    logic [31:0]                 pram_data;

    // onchip_flash data slave
    logic [FLASH_ADDR_WIDTH-1:0] avmm_data_addr;
    logic                        avmm_data_write;
    logic [31:0]                 avmm_data_writedata;
    logic                        avmm_data_waitrequest;
    logic                        avmm_data_read;
    logic [31:0]                 avmm_data_readdata;
    logic                        avmm_data_readdatavalid;

    // onchip_flash CSR slave
    logic                        avmm_csr_addr;
    logic                        avmm_csr_read;
    logic                        avmm_csr_write;
    logic [31:0]                 avmm_csr_writedata;
    logic [31:0]                 avmm_csr_readdata;

    modport master (
        output pram_re, pram_addr,
        input  pram_data,
        output avmm_data_addr, avmm_data_write, avmm_data_writedata, avmm_data_read,
        input  avmm_data_waitrequest, avmm_data_readdata, avmm_data_readdatavalid,
        output avmm_csr_addr, avmm_csr_read, avmm_csr_write, avmm_csr_writedata,
        input  avmm_csr_readdata
    );

    modport slave (
        input  pram_re, pram_addr,
        output pram_data,
        input  avmm_data_addr, avmm_data_write, avmm_data_writedata, avmm_data_read,
        output avmm_data_waitrequest, avmm_data_readdata, avmm_data_readdatavalid,
        input  avmm_csr_addr, avmm_csr_read, avmm_csr_write, avmm_csr_writedata,
        output avmm_csr_readdata
    );
endinterface

// File: rtl/code_mem_flash_writer.sv
// Code RAM -> UFM programmer. Unprotects the flash, erases every page of the
// region selected by page_index, then copies each code RAM word (byte
// reversed, so the power-on loader's swap restores it) into flash, polling
// the CSR status register after each erase and write, and finally restores
// write protection.
// Optional build macro: FLASH_WRITE_VERIFY_EN -- read back every programmed
// word and flag an error on mismatch.
module code_mem_flash_writer #(
    parameter int         ON_CHIP_CODE_RAM_SIZE_IN_BYTES = 32768,
    parameter int         FLASH_ADDR_WIDTH               = 13,
    parameter int         FLASH_PAGE_WORDS               = 512,
    parameter logic [4:0] WP_CLEAR_MASK                  = 5'b00000,
    parameter logic [4:0] WP_SET_MASK                    = 5'b11111,
    parameter int         POLL_TIMEOUT                   = 65535
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] page_index,
    output logic       busy,
    output logic       done,
    output logic       error,
    code_mem_flash_writer_if.master bus
);
    localparam int W      = ON_CHIP_CODE_RAM_SIZE_IN_BYTES / 4;
    localparam int AW     = $clog2(W);
    localparam int NPAGES = W / FLASH_PAGE_WORDS;
    localparam int PGW    = $clog2(FLASH_PAGE_WORDS);

    localparam logic [AW-1:0] LAST_WORD  = AW'(W - 1);
    localparam logic [15:0]   LAST_PAGE  = 16'(NPAGES - 1);
    localparam logic [15:0]   POLL_LIMIT = 16'(POLL_TIMEOUT);

    // Control word: {4'b0, wp[4:0], 3'b111, erase_addr[19:0]}; 0xFFFFF = no erase
    localparam logic [31:0] CTRL_UNPROTECT = {4'b0, WP_CLEAR_MASK, 3'b111, 20'hFFFFF};
    localparam logic [31:0] CTRL_PROTECT   = {4'b0, WP_SET_MASK, 3'b111, 20'hFFFFF};

    typedef enum logic [3:0] {
        S_IDLE,
        S_UNPROTECT,
        S_ERASE,
        S_ERASE_POLL,
        S_PRAM_READ,
        S_PRAM_LATCH,
        S_FLASH_WRITE,
        S_WRITE_POLL,
`ifdef FLASH_WRITE_VERIFY_EN
        S_VERIFY,
`endif
        S_PROTECT,
        S_ERR
    } state_t;

    state_t         r_state, w_state_next;
    logic [3:0]     r_page_index, w_page_index_next;
    logic [15:0]    r_page_cnt, w_page_cnt_next;
    logic [AW-1:0]  r_word_cnt, w_word_cnt_next;
    logic [15:0]    r_poll_cnt, w_poll_cnt_next;
    logic           r_phase, w_phase_next;
    logic [31:0]    r_wdata, w_wdata_next;
    logic           r_busy, w_busy_next;
    logic           r_done, w_done_next;
    logic           r_error, w_error_next;

    logic [31:0]                 w_pram_swapped;
    logic [19:0]                 w_erase_addr;
    logic [FLASH_ADDR_WIDTH-1:0] w_data_addr;
    logic [15:0]                 w_poll_inc;
    logic                        w_stat_idle;

    // Byte reversal of the code RAM word on its way to flash
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_byte_rev
            assign w_pram_swapped[8*gi +: 8] = bus.pram_data[8*(3-gi) +: 8];
        end
    endgenerate

    // Erase byte address {page_index, page_cnt, page offset zeros, 2'b00}
    assign w_erase_addr = 20'(((32'(r_page_index) << AW) | (32'(r_page_cnt) << PGW)) << 2);
    // Flash word address {zeros, page_index, word_cnt}
    assign w_data_addr  = FLASH_ADDR_WIDTH'((32'(r_page_index) << AW) | 32'(r_word_cnt));
    assign w_poll_inc   = r_poll_cnt + 16'd1;
    assign w_stat_idle  = (bus.avmm_csr_readdata[1:0] == 2'b00);

    assign busy  = r_busy;
    assign done  = r_done;
    assign error = r_error;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_page_index <= '0;
            r_page_cnt   <= '0;
            r_word_cnt   <= '0;
            r_poll_cnt   <= '0;
            r_phase      <= 1'b0;
            r_wdata      <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_page_index <= w_page_index_next;
            r_page_cnt   <= w_page_cnt_next;
            r_word_cnt   <= w_word_cnt_next;
            r_poll_cnt   <= w_poll_cnt_next;
            r_phase      <= w_phase_next;
            r_wdata      <= w_wdata_next;
            r_busy       <= w_busy_next;
            r_done       <= w_done_next;
            r_error      <= w_error_next;
        end
    end

    // Next-state and bus strobe decode; poll phases alternate read / sample
    always_comb begin
        w_state_next      = r_state;
        w_page_index_next = r_page_index;
        w_page_cnt_next   = r_page_cnt;
        w_word_cnt_next   = r_word_cnt;
        w_poll_cnt_next   = '0;
        w_phase_next      = 1'b0;
        w_wdata_next      = r_wdata;
        w_busy_next       = r_busy;
        w_done_next       = r_done;
        w_error_next      = r_error;

        bus.pram_re             = 1'b0;
        bus.pram_addr           = r_word_cnt;
        bus.avmm_data_addr      = w_data_addr;
        bus.avmm_data_write     = 1'b0;
        bus.avmm_data_writedata = r_wdata;
        bus.avmm_data_read      = 1'b0;
        bus.avmm_csr_addr       = 1'b0;
        bus.avmm_csr_read       = 1'b0;
        bus.avmm_csr_write      = 1'b0;
        bus.avmm_csr_writedata  = '0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_page_index_next = page_index;
                    w_done_next       = 1'b0;
                    w_error_next      = 1'b0;
                    w_busy_next       = 1'b1;
                    w_page_cnt_next   = '0;
                    w_word_cnt_next   = '0;
                    w_state_next      = S_UNPROTECT;
                end
            end

            S_UNPROTECT: begin
                bus.avmm_csr_addr      = 1'b1;
                bus.avmm_csr_write     = 1'b1;
                bus.avmm_csr_writedata = CTRL_UNPROTECT;
                w_state_next           = S_ERASE;
            end

            S_ERASE: begin
                bus.avmm_csr_addr      = 1'b1;
                bus.avmm_csr_write     = 1'b1;
                bus.avmm_csr_writedata = {4'b0, WP_CLEAR_MASK, 3'b111, w_erase_addr};
                w_state_next           = S_ERASE_POLL;
            end

            S_ERASE_POLL: begin
                if (!r_phase) begin
                    bus.avmm_csr_read = 1'b1;
                    w_phase_next      = 1'b1;
                    w_poll_cnt_next   = r_poll_cnt;
                end else if (w_stat_idle) begin
                    if (bus.avmm_csr_readdata[4]) begin
                        if (r_page_cnt == LAST_PAGE) begin
                            w_state_next = S_PRAM_READ;
                        end else begin
                            w_page_cnt_next = r_page_cnt + 16'd1;
                            w_state_next    = S_ERASE;
                        end
                    end else begin
                        w_state_next = S_ERR;
                    end
                end else if (w_poll_inc == POLL_LIMIT) begin
                    w_state_next = S_ERR;
                end else begin
                    w_poll_cnt_next = w_poll_inc;
                end
            end

            S_PRAM_READ: begin
                bus.pram_re  = 1'b1;
                w_state_next = S_PRAM_LATCH;
            end

            S_PRAM_LATCH: begin
                w_wdata_next = w_pram_swapped;
                w_state_next = S_FLASH_WRITE;
            end

            S_FLASH_WRITE: begin
                bus.avmm_data_write = 1'b1;
                if (!bus.avmm_data_waitrequest) begin
                    w_state_next = S_WRITE_POLL;
                end
            end

            S_WRITE_POLL: begin
                if (!r_phase) begin
                    bus.avmm_csr_read = 1'b1;
                    w_phase_next      = 1'b1;
                    w_poll_cnt_next   = r_poll_cnt;
                end else if (w_stat_idle) begin
                    if (bus.avmm_csr_readdata[3]) begin
`ifdef FLASH_WRITE_VERIFY_EN
                        w_state_next = S_VERIFY;
`else
                        if (r_word_cnt == LAST_WORD) begin
                            w_state_next = S_PROTECT;
                        end else begin
                            w_word_cnt_next = r_word_cnt + 1'b1;
                            w_state_next    = S_PRAM_READ;
                        end
`endif
                    end else begin
                        w_state_next = S_ERR;
                    end
                end else if (w_poll_inc == POLL_LIMIT) begin
                    w_state_next = S_ERR;
                end else begin
                    w_poll_cnt_next = w_poll_inc;
                end
            end

`ifdef FLASH_WRITE_VERIFY_EN
            S_VERIFY: begin
                // phase 0: issue the read until accepted; phase 1: await data
                if (!r_phase) begin
                    bus.avmm_data_read = 1'b1;
                    if (!bus.avmm_data_waitrequest) begin
                        w_phase_next = 1'b1;
                    end
                end else if (bus.avmm_data_readdatavalid) begin
                    if (bus.avmm_data_readdata != r_wdata) begin
                        w_state_next = S_ERR;
                    end else if (r_word_cnt == LAST_WORD) begin
                        w_state_next = S_PROTECT;
                    end else begin
                        w_word_cnt_next = r_word_cnt + 1'b1;
                        w_state_next    = S_PRAM_READ;
                    end
                end else if (w_poll_inc == POLL_LIMIT) begin
                    w_state_next = S_ERR;
                end else begin
                    w_phase_next    = 1'b1;
                    w_poll_cnt_next = w_poll_inc;
                end
            end
`endif

            S_PROTECT: begin
                bus.avmm_csr_addr      = 1'b1;
                bus.avmm_csr_write     = 1'b1;
                bus.avmm_csr_writedata = CTRL_PROTECT;
                w_done_next            = 1'b1;
                w_busy_next            = 1'b0;
                w_state_next           = S_IDLE;
            end

            S_ERR: begin
                bus.avmm_csr_addr      = 1'b1;
                bus.avmm_csr_write     = 1'b1;
                bus.avmm_csr_writedata = CTRL_PROTECT;
                w_error_next           = 1'b1;
                w_busy_next            = 1'b0;
                w_state_next           = S_IDLE;
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_code_mem_flash_writer.sv
// Directed bench for code_mem_flash_writer with W=16 words, 8-word pages.
// Code RAM and onchip_flash (data + CSR) are behavioural models; expected
// CSR writes and flash data writes are queued before each run and checked
// as the DUT issues them.
module tb_code_mem_flash_writer;
    localparam int W          = 16;
    localparam int AW         = 4;
    localparam int FAW        = 13;
    localparam int PAGE_WORDS = 8;

    typedef struct packed {
        logic [FAW-1:0] addr;
        logic [31:0]    data;
    } wr_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] page_index = 4'd0;
    logic       busy, done, error;

    code_mem_flash_writer_if #(.AW(AW), .FLASH_ADDR_WIDTH(FAW)) bus ();

    code_mem_flash_writer #(
        .ON_CHIP_CODE_RAM_SIZE_IN_BYTES(W * 4),
        .FLASH_ADDR_WIDTH(FAW),
        .FLASH_PAGE_WORDS(PAGE_WORDS),
        .WP_CLEAR_MASK(5'b00000),
        .WP_SET_MASK(5'b11111),
        .POLL_TIMEOUT(65535)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .page_index(page_index),
        .busy(busy),
        .done(done),
        .error(error),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [31:0] csr_q[$];
    wr_t         data_q[$];

    function automatic logic [31:0] pop_csr();
        if (csr_q.size() == 0) return 32'hxxxxxxxx;
        return csr_q.pop_front();
    endfunction

    function automatic wr_t pop_data();
        wr_t e;
        e = 'x;
        if (data_q.size() != 0) e = data_q.pop_front();
        return e;
    endfunction

    // ---------------- model configuration (written by stimulus) ----------------
    int          stall_word = -1;
    int          fail_word = -1;
    int          corrupt_word = -1;
    int          erase_busy_polls = 0;
    logic [31:0] erase_ok = 32'h18;
    logic [31:0] write_ok = 32'h18;
    logic [31:0] ram [W];

    // ---------------- model state (written by the model only) ----------------
    int          data_wr_cnt, csr_wr_cnt, erase_cnt, erase0_reads;
    int          stall_cycles, stall_left, busy_left, last_word;
    bit          last_op_erase;
    logic [31:0] last_csr_wd, stall_wd;
    logic [FAW-1:0] stall_addr;
    logic [31:0] flash_mem [W];

    assign bus.avmm_data_waitrequest = bus.avmm_data_write &&
                                       (int'(bus.avmm_data_addr[3:0]) == stall_word) &&
                                       (stall_left > 0);

    // code RAM: registered read
    always @(posedge clk) begin
        if (bus.pram_re) bus.pram_data <= ram[bus.pram_addr];
    end

    // onchip_flash data + CSR model, scoreboard pops
    always @(posedge clk) begin
        bus.avmm_data_readdatavalid <= 1'b0;
        if (reset || (start && !busy)) begin
            data_wr_cnt   <= 0;
            csr_wr_cnt    <= 0;
            erase_cnt     <= 0;
            erase0_reads  <= 0;
            stall_cycles  <= 0;
            stall_left    <= 5;
            busy_left     <= 0;
            last_word     <= -1;
            last_op_erase <= 1'b0;
            if (reset) begin
                bus.avmm_csr_readdata  <= '0;
                bus.avmm_data_readdata <= '0;
            end
        end else begin
            check("one_strobe", 128'($countones({bus.avmm_csr_read, bus.avmm_csr_write,
                                                 bus.avmm_data_write, bus.avmm_data_read}) <= 1), 128'(1));
            if (bus.avmm_csr_write) begin
                $display("csr write data=0x%08h", bus.avmm_csr_writedata);
                check("csr_wr_addr", 128'(bus.avmm_csr_addr), 128'(1));
                check("csr_wr_data", 128'(bus.avmm_csr_writedata), 128'(pop_csr()));
                csr_wr_cnt  <= csr_wr_cnt + 1;
                last_csr_wd <= bus.avmm_csr_writedata;
                if (bus.avmm_csr_writedata[19:0] != 20'hFFFFF) begin
                    erase_cnt     <= erase_cnt + 1;
                    last_op_erase <= 1'b1;
                    busy_left     <= (erase_cnt == 0) ? erase_busy_polls : 0;
                end
            end
            if (bus.avmm_csr_read) begin
                check("csr_rd_addr", 128'(bus.avmm_csr_addr), 128'(0));
                if (erase_cnt == 1) erase0_reads <= erase0_reads + 1;
                if (busy_left > 0) begin
                    bus.avmm_csr_readdata <= 32'h1;
                    busy_left             <= busy_left - 1;
                end else if (last_op_erase) begin
                    bus.avmm_csr_readdata <= erase_ok;
                end else if (last_word == fail_word) begin
                    bus.avmm_csr_readdata <= 32'h0;
                end else begin
                    bus.avmm_csr_readdata <= write_ok;
                end
            end
            if (bus.avmm_data_write) begin
                if (bus.avmm_data_waitrequest) begin
                    stall_left   <= stall_left - 1;
                    stall_cycles <= stall_cycles + 1;
                    if (stall_left == 5) begin
                        stall_addr <= bus.avmm_data_addr;
                        stall_wd   <= bus.avmm_data_writedata;
                    end else begin
                        check("stall_addr", 128'(bus.avmm_data_addr), 128'(stall_addr));
                        check("stall_data", 128'(bus.avmm_data_writedata), 128'(stall_wd));
                    end
                end else begin
                    wr_t e;
                    e = pop_data();
                    $display("flash write addr=0x%04h data=0x%08h", bus.avmm_data_addr, bus.avmm_data_writedata);
                    check("wr_addr", 128'(bus.avmm_data_addr), 128'(e.addr));
                    check("wr_data", 128'(bus.avmm_data_writedata), 128'(e.data));
                    if (stall_cycles > 0 && int'(bus.avmm_data_addr[3:0]) == stall_word) begin
                        check("stall_accept_addr", 128'(bus.avmm_data_addr), 128'(stall_addr));
                        check("stall_accept_data", 128'(bus.avmm_data_writedata), 128'(stall_wd));
                    end
                    flash_mem[bus.avmm_data_addr[3:0]] <= bus.avmm_data_writedata;
                    data_wr_cnt   <= data_wr_cnt + 1;
                    last_op_erase <= 1'b0;
                    last_word     <= int'(bus.avmm_data_addr[3:0]);
                    busy_left     <= 0;
                end
            end
            if (bus.avmm_data_read) begin
                $display("flash read addr=0x%04h", bus.avmm_data_addr);
                bus.avmm_data_readdatavalid <= 1'b1;
                bus.avmm_data_readdata <= flash_mem[bus.avmm_data_addr[3:0]] ^
                    ((int'(bus.avmm_data_addr[3:0]) == corrupt_word) ? 32'h1 : 32'h0);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [127:0] out_vec();
        return 128'({busy, done, error, bus.pram_re, bus.pram_addr, bus.avmm_data_addr,
                     bus.avmm_data_write, bus.avmm_data_writedata, bus.avmm_data_read,
                     bus.avmm_csr_addr, bus.avmm_csr_read, bus.avmm_csr_write,
                     bus.avmm_csr_writedata});
    endfunction

    task automatic set_cfg(input int sw, input int fw, input int cw, input int eb, input logic [31:0] eok);
        stall_word       = sw;
        fail_word        = fw;
        corrupt_word     = cw;
        erase_busy_polls = eb;
        erase_ok         = eok;
        write_ok         = 32'h18;
    endtask

    // unprotect, two page erases, nwords data writes, protect
    task automatic push_run(input int pg, input int nwords);
        logic [31:0] d;
        csr_q.push_back(32'h007FFFFF);
        for (int p = 0; p < 2; p++)
            csr_q.push_back({12'h007, 20'((pg * W + p * PAGE_WORDS) * 4)});
        for (int i = 0; i < nwords; i++) begin
            d = 32'h11223344 + 32'(i);
            data_q.push_back('{addr: FAW'(pg * W + i), data: {d[7:0], d[15:8], d[23:16], d[31:24]}});
        end
        csr_q.push_back(32'h0FFFFFFF);
    endtask

    task automatic pulse_start(input logic [3:0] pg);
        @(negedge clk);
        page_index = pg;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int c = 0;
        while (busy && c < budget) begin
            @(negedge clk);
            c++;
        end
        check({tag, "_timeout"}, 128'(busy), 128'(0));
    endtask

    task automatic wait_word7(input int budget);
        int c = 0;
        while (!(bus.pram_re && bus.pram_addr == 4'd7) && c < budget) begin
            @(negedge clk);
            c++;
        end
        check("r5_reach_w7", 128'(bus.pram_re && bus.pram_addr == 4'd7), 128'(1));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        for (int i = 0; i < W; i++) ram[i] = 32'h11223344 + 32'(i);

        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", out_vec(), 128'(0));
        reset = 1'b0;

        // R1: plain programming of region 3; a start while busy is ignored
        set_cfg(-1, -1, -1, 0, 32'h18);
        push_run(3, 16);
        pulse_start(4'd3);
        check("r1_busy_on_start", 128'(busy), 128'(1));
        repeat (20) @(negedge clk);
        pulse_start(4'd0);
        wait_idle("r1", 2000);
        check("r1_done", 128'(done), 128'(1));
        check("r1_error", 128'(error), 128'(0));
        check("r1_data_writes", 128'(data_wr_cnt), 128'(16));
        check("r1_erase_writes", 128'(erase_cnt), 128'(2));
        check("r1_first_word", 128'(flash_mem[0]), 128'(32'h44332211));
        check("r1_last_word", 128'(flash_mem[15]), 128'(32'h53332211));
        check("r1_csr_q_empty", 128'(csr_q.size()), 128'(0));
        check("r1_data_q_empty", 128'(data_q.size()), 128'(0));

        // R2: waitrequest held for 5 cycles on word 2
        set_cfg(2, -1, -1, 0, 32'h18);
        push_run(3, 16);
        pulse_start(4'd3);
        check("r2_done_cleared", 128'(done), 128'(0));
        wait_idle("r2", 2000);
        check("r2_stall_cycles", 128'(stall_cycles), 128'(5));
        check("r2_data_writes", 128'(data_wr_cnt), 128'(16));
        check("r2_word2", 128'(flash_mem[2]), 128'(32'h46332211));
        check("r2_done", 128'(done), 128'(1));
        check("r2_data_q_empty", 128'(data_q.size()), 128'(0));

        // R3: first erase reports busy for 10 polls, then 0x10
        set_cfg(-1, -1, -1, 10, 32'h10);
        push_run(3, 16);
        pulse_start(4'd3);
        wait_idle("r3", 2000);
        check("r3_erase0_reads", 128'(erase0_reads), 128'(11));
        check("r3_data_writes", 128'(data_wr_cnt), 128'(16));
        check("r3_done", 128'(done), 128'(1));

        // R4: write status without bit3 on word 5
        set_cfg(-1, 5, -1, 0, 32'h18);
        push_run(3, 6);
        pulse_start(4'd3);
        wait_idle("r4", 2000);
        check("r4_error", 128'(error), 128'(1));
        check("r4_done", 128'(done), 128'(0));
        check("r4_protect_word", 128'(last_csr_wd), 128'(32'h0FFFFFFF));
        repeat (20) @(negedge clk);
        check("r4_data_writes", 128'(data_wr_cnt), 128'(6));
        check("r4_csr_q_empty", 128'(csr_q.size()), 128'(0));
        check("r4_data_q_empty", 128'(data_q.size()), 128'(0));

        // R5: reset while word 7 is being fetched, then a clean restart
        set_cfg(-1, -1, -1, 0, 32'h18);
        push_run(3, 16);
        pulse_start(4'd3);
        check("r5_error_cleared", 128'(error), 128'(0));
        wait_word7(2000);
        check("r5_writes_before_reset", 128'(data_wr_cnt), 128'(7));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("r5_reset_outputs", out_vec(), 128'(0));
        csr_q.delete();
        data_q.delete();
        repeat (5) @(negedge clk);
        check("r5_no_csr_after_reset", 128'(csr_wr_cnt), 128'(0));
        check("r5_no_data_after_reset", 128'(data_wr_cnt), 128'(0));
        push_run(3, 16);
        pulse_start(4'd3);
        wait_idle("r5", 2000);
        check("r5_done", 128'(done), 128'(1));
        check("r5_data_writes", 128'(data_wr_cnt), 128'(16));
        check("r5_csr_q_empty", 128'(csr_q.size()), 128'(0));

        // R6: read-back of word 4 corrupted
        set_cfg(-1, -1, 4, 0, 32'h18);
`ifdef FLASH_WRITE_VERIFY_EN
        push_run(3, 5);
`else
        push_run(3, 16);
`endif
        pulse_start(4'd3);
        wait_idle("r6", 2000);
`ifdef FLASH_WRITE_VERIFY_EN
        check("r6_error", 128'(error), 128'(1));
        check("r6_done", 128'(done), 128'(0));
        check("r6_data_writes", 128'(data_wr_cnt), 128'(5));
`else
        check("r6_error", 128'(error), 128'(0));
        check("r6_done", 128'(done), 128'(1));
        check("r6_data_writes", 128'(data_wr_cnt), 128'(16));
`endif
        check("r6_csr_q_empty", 128'(csr_q.size()), 128'(0));
        check("r6_data_q_empty", 128'(data_q.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
